// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence detector.
//   state_t         : detector FSM states
//   PAT_LEN         : length of one pattern period in bits
//   DEFAULT_PATTERN : default period, bit k is sent at period position k
package seq_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int              PAT_LEN         = 6;
    localparam logic [PAT_LEN-1:0] DEFAULT_PATTERN = 6'b110100;

endpackage

// File: rtl/sequence_window.sv
// Serial shift window with fill counter and pattern compare.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   i_valid  : shift i_data into the window this cycle
//   i_data   : serial bit
//   o_match  : combinational; high when the window after this shift is
//              full and equals PATTERN (only while i_valid is high)
module sequence_window
    import seq_pkg::*;
#(
    parameter logic [PAT_LEN-1:0] PATTERN = DEFAULT_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    input  logic i_data,
    output logic o_match
);

    logic [PAT_LEN-1:0] r_window;
    logic [2:0]         r_fill;
    logic [PAT_LEN-1:0] w_window_next;
    logic               w_full_next;

    // Newest bit enters at the MSB so a complete period lines up with PATTERN.
    assign w_window_next = {i_data, r_window[PAT_LEN-1:1]};
    assign w_full_next   = (r_fill >= 3'(PAT_LEN - 1));
    assign o_match       = i_valid && w_full_next && (w_window_next == PATTERN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_window <= '0;
            r_fill   <= '0;
        end else if (i_valid) begin
            r_window <= w_window_next;
            if (r_fill != 3'(PAT_LEN))
                r_fill <= r_fill + 3'd1;
        end
    end

endmodule

// File: rtl/sequence_detector.sv
// Serial pattern detector with hunt / verify / lock tracking and error count.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   data_in    : serial bit under test
//   data_valid : data_in is sampled only when high
//   clr_err    : synchronous clear of err_cnt
//   match      : one-cycle pulse when the window equals PATTERN
//   locked     : high while in LOCKED
//   err        : one-cycle pulse on a bit mismatch while locked
//   err_cnt    : saturating bit-error count
//   phase      : expected period index of the next bit, 0 when not locked
//
// state  | meaning
// HUNT   | searching the window for a full pattern
// VERIFY | checking clean periods after the first match
// LOCKED | tracking phase, counting bit errors
module sequence_detector
    import seq_pkg::*;
#(
    parameter logic [PAT_LEN-1:0] PATTERN      = DEFAULT_PATTERN,
    parameter int                 LOCK_PERIODS = 2,
    parameter int                 UNLOCK_ERRS  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    input  logic       data_valid,
    input  logic       clr_err,
    output logic       match,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_cnt,
    output logic [2:0] phase
);

    localparam logic [7:0] LOCK_N   = 8'(LOCK_PERIODS);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_ERRS);

    state_t     r_state;
    logic [2:0] r_idx;
    logic [7:0] r_clean;
    logic [7:0] r_acc;
    logic       r_per_err;

    logic       w_win_match;
    logic       w_bit_ok;
    logic       w_wrap;
    logic [2:0] w_idx_next;
    logic [7:0] w_acc_inc;

    sequence_window #(
        .PATTERN (PATTERN)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .i_valid (data_valid),
        .i_data  (data_in),
        .o_match (w_win_match)
    );

    assign w_bit_ok   = (data_in == PATTERN[r_idx]);
    assign w_wrap     = (r_idx == 3'(PAT_LEN - 1));
    assign w_idx_next = w_wrap ? 3'd0 : r_idx + 3'd1;
    assign w_acc_inc  = r_acc + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= HUNT;
            r_idx     <= '0;
            r_clean   <= '0;
            r_acc     <= '0;
            r_per_err <= 1'b0;
            match     <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            phase     <= '0;
        end else begin
            match <= 1'b0;
            err   <= 1'b0;
            if (data_valid) begin
                match <= w_win_match;
                case (r_state)
                    HUNT: begin
                        if (w_win_match) begin
                            r_state <= VERIFY;
                            r_idx   <= '0;
                            r_clean <= '0;
                        end
                    end
                    VERIFY: begin
                        if (!w_bit_ok) begin
                            // Window is kept; the next bit is hunted normally.
                            r_state <= HUNT;
                            r_idx   <= '0;
                            r_clean <= '0;
                        end else begin
                            r_idx <= w_idx_next;
                            if (w_wrap) begin
                                if (r_clean + 8'd1 == LOCK_N) begin
                                    r_state   <= LOCKED;
                                    r_clean   <= '0;
                                    r_acc     <= '0;
                                    r_per_err <= 1'b0;
                                    locked    <= 1'b1;
                                    phase     <= '0;
                                end else begin
                                    r_clean <= r_clean + 8'd1;
                                end
                            end
                        end
                    end
                    LOCKED: begin
                        if (!w_bit_ok) begin
                            err <= 1'b1;
                            if (err_cnt != 8'hFF)
                                err_cnt <= err_cnt + 8'd1;
                        end
                        if (!w_bit_ok && (w_acc_inc == UNLOCK_N)) begin
                            r_state   <= HUNT;
                            r_idx     <= '0;
                            r_acc     <= '0;
                            r_per_err <= 1'b0;
                            locked    <= 1'b0;
                            phase     <= '0;
                        end else begin
                            r_idx <= w_idx_next;
                            phase <= w_idx_next;
                            if (!w_bit_ok)
                                r_acc <= w_acc_inc;
                            if (w_wrap) begin
                                // Only a fully clean period forgives earlier errors.
                                r_per_err <= 1'b0;
                                if (w_bit_ok && !r_per_err)
                                    r_acc <= '0;
                            end else if (!w_bit_ok) begin
                                r_per_err <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= HUNT;
                        r_idx   <= '0;
                        locked  <= 1'b0;
                        phase   <= '0;
                    end
                endcase
            end
            // Last assignment wins: clear beats a same-cycle increment.
            if (clr_err)
                err_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_sequence_detector.sv
// Directed bench for sequence_detector with a bit-history reference model.
module tb_sequence_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_in = 1'b0;
    logic       data_valid = 1'b0;
    logic       clr_err = 1'b0;
    logic       match;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic [2:0] phase;

    int checks   = 0;
    int failures = 0;

    logic [5:0] pat_v = 6'b110100;
    localparam int LOCK_P = 2;
    localparam int UNLOCK = 3;

    sequence_detector dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clr_err    (clr_err),
        .match      (match),
        .locked     (locked),
        .err        (err),
        .err_cnt    (err_cnt),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    // Reference model: recent bit history, a mode, and counters of bits/errors.
    int  hist[$];
    int  m_mode = 0;        // 0 searching, 1 confirming, 2 locked
    int  m_pos = 0;
    int  m_good = 0;
    int  m_errs = 0;
    int  m_perr = 0;
    int  m_cnt = 0;
    int  exp_match = 0, exp_err = 0, exp_locked = 0, exp_phase = 0;
    bit  model_on = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic b, input logic v, input logic c, input logic r);
        bit hit;
        exp_match = 0;
        exp_err   = 0;
        if (r) begin
            hist.delete();
            m_mode = 0; m_pos = 0; m_good = 0; m_errs = 0; m_perr = 0; m_cnt = 0;
        end else begin
            if (v) begin
                hist.push_back(int'(b));
                if (hist.size() > 6) void'(hist.pop_front());
                hit = (hist.size() == 6);
                for (int i = 0; i < 6; i++)
                    if (hist.size() == 6 && hist[i] != int'(pat_v[i])) hit = 0;
                exp_match = hit;
                if (m_mode == 0) begin
                    if (hit) begin m_mode = 1; m_pos = 0; m_good = 0; end
                end else if (m_mode == 1) begin
                    if (int'(b) != int'(pat_v[m_pos])) m_mode = 0;
                    else begin
                        m_good++;
                        m_pos = (m_pos + 1) % 6;
                        if (m_good == 6 * LOCK_P) begin
                            m_mode = 2; m_pos = 0; m_errs = 0; m_perr = 0;
                        end
                    end
                end else begin
                    if (int'(b) != int'(pat_v[m_pos])) begin
                        exp_err = 1;
                        if (m_cnt < 255) m_cnt++;
                        m_errs++;
                        m_perr = 1;
                    end
                    if (m_errs == UNLOCK) begin
                        m_mode = 0; m_pos = 0;
                    end else begin
                        if (m_pos == 5) begin
                            if (m_perr == 0) m_errs = 0;
                            m_perr = 0;
                        end
                        m_pos = (m_pos + 1) % 6;
                    end
                end
            end
            if (c) m_cnt = 0;
        end
        exp_locked = (m_mode == 2);
        exp_phase  = (m_mode == 2) ? m_pos : 0;
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("match",   int'(match),   exp_match);
            chk("err",     int'(err),     exp_err);
            chk("locked",  int'(locked),  exp_locked);
            chk("err_cnt", int'(err_cnt), m_cnt);
            chk("phase",   int'(phase),   exp_phase);
        end
    end

    task automatic step(input logic b, input logic v, input logic c, input logic r);
        data_in = b; data_valid = v; clr_err = c; rst = r;
        @(posedge clk);
        model_step(b, v, c, r);
        #1;
    endtask

    task automatic send_pos(input int k, input bit inv = 0, input bit c = 0);
        step(pat_v[k] ^ inv, 1'b1, c, 1'b0);
    endtask

    task automatic send_periods(input int n);
        for (int p = 0; p < n; p++)
            for (int k = 0; k < 6; k++) send_pos(k);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_match"},   int'(match),   0);
        chk({tag, "_locked"},  int'(locked),  0);
        chk({tag, "_err"},     int'(err),     0);
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
        chk({tag, "_phase"},   int'(phase),   0);
    endtask

    initial begin
        step(0, 0, 0, 1);
        model_on = 1;
        step(0, 0, 0, 1);
        chk_zero("reset");

        // Clean stream: match after 6, 12, 18; lock after 18.
        for (int i = 1; i <= 18; i++) begin
            send_pos((i - 1) % 6);
            if (i == 6 || i == 12 || i == 18) chk("lit_match_bit", int'(match), 1);
            if (i == 7) chk("lit_nomatch_7", int'(match), 0);
            if (i == 17) chk("lit_locked_17", int'(locked), 0);
        end
        chk("lit_locked_18", int'(locked), 1);
        chk("lit_phase_18", int'(phase), 0);
        chk("lit_cnt_18", int'(err_cnt), 0);

        // Single error at phase 2 keeps lock.
        send_pos(0); send_pos(1); send_pos(2, 1);
        chk("lit_err_p2", int'(err), 1);
        chk("lit_cnt_p2", int'(err_cnt), 1);
        chk("lit_lock_p2", int'(locked), 1);
        for (int k = 3; k < 6; k++) send_pos(k);
        send_periods(1);
        // Error with simultaneous clear: pulse still fires, count goes to 0.
        for (int k = 0; k < 4; k++) send_pos(k);
        send_pos(4, 1, 1);
        chk("lit_err_clr", int'(err), 1);
        chk("lit_cnt_clr", int'(err_cnt), 0);
        send_pos(5);
        send_periods(1);
        send_pos(0, 1);
        chk("lit_lock_after_forgive", int'(locked), 1);
        chk("lit_cnt_after_forgive", int'(err_cnt), 1);
        for (int k = 1; k < 6; k++) send_pos(k);
        send_periods(1);

        // Valid gap mid-period.
        send_pos(0); send_pos(1); send_pos(2);
        for (int g = 0; g < 10; g++) begin
            step(logic'($urandom_range(0, 1)), 0, 0, 0);
            chk("lit_gap_phase", int'(phase), 3);
            chk("lit_gap_locked", int'(locked), 1);
        end
        for (int k = 3; k < 6; k++) begin
            send_pos(k);
            chk("lit_gap_noerr", int'(err), 0);
        end
        chk("lit_gap_cnt", int'(err_cnt), 1);

        // Three errors within one period drop lock.
        send_pos(0, 0, 1);
        for (int k = 1; k < 6; k++) send_pos(k);
        send_pos(0, 1); send_pos(1, 1);
        chk("lit_lock_2err", int'(locked), 1);
        send_pos(2, 1);
        chk("lit_unlock", int'(locked), 0);
        chk("lit_unlock_phase", int'(phase), 0);
        chk("lit_unlock_cnt", int'(err_cnt), 3);
        for (int k = 3; k < 6; k++) send_pos(k);
        send_periods(2);
        for (int k = 0; k < 5; k++) send_pos(k);
        chk("lit_relock_early", int'(locked), 0);
        send_pos(5);
        chk("lit_relock", int'(locked), 1);
        chk("lit_relock_cnt", int'(err_cnt), 3);

        // Mismatch during confirmation.
        step(0, 0, 0, 1);
        send_periods(1);
        send_pos(0); send_pos(1); send_pos(2, 1);
        chk("lit_ver_locked", int'(locked), 0);
        chk("lit_ver_err", int'(err), 0);
        chk("lit_ver_cnt", int'(err_cnt), 0);
        for (int k = 3; k < 6; k++) send_pos(k);
        send_periods(3);
        chk("lit_ver_relock", int'(locked), 1);

        // Reset while locked with err_cnt 5.
        step(0, 0, 0, 1);
        send_periods(3);
        for (int r = 0; r < 2; r++) begin
            send_pos(0, 1); send_pos(1, 1);
            for (int k = 2; k < 6; k++) send_pos(k);
            send_periods(1);
        end
        send_pos(0, 1);
        for (int k = 1; k < 6; k++) send_pos(k);
        chk("lit_cnt5", int'(err_cnt), 5);
        chk("lit_cnt5_locked", int'(locked), 1);
        step(pat_v[0], 1, 0, 1);
        chk_zero("rst_locked");

        // Junk prefix.
        step(1, 1, 0, 0); step(1, 1, 0, 0);
        for (int i = 3; i <= 20; i++) begin
            send_pos((i - 3) % 6);
            if (i == 7) chk("lit_junk_nomatch7", int'(match), 0);
            if (i == 8) chk("lit_junk_match8", int'(match), 1);
            if (i == 19) chk("lit_junk_lock19", int'(locked), 0);
        end
        chk("lit_junk_lock20", int'(locked), 1);

        // Saturation of err_cnt.
        for (int r = 0; r < 130; r++) begin
            send_pos(0); send_pos(1, 1); send_pos(2); send_pos(3, 1);
            send_pos(4); send_pos(5);
            send_periods(1);
        end
        chk("lit_sat_cnt", int'(err_cnt), 255);
        chk("lit_sat_locked", int'(locked), 1);

        step(0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sequence_detector.md
SEQUENCE_DETECTOR -- requirements
Module: sequence_detector

Interface
REQ-001 SHALL have parameter PATTERN, default 6'b110100, the expected period; bit k is sent at period position k, so serial order is 0,0,1,0,1,1.
REQ-002 SHALL have parameter LOCK_PERIODS, default 2, the count of consecutive clean periods after the first match that are needed to lock.
REQ-003 SHALL have parameter UNLOCK_ERRS, default 3, the bit-error count that drops lock when no clean period comes between the errors.
REQ-004 SHALL have port clk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port data_in, input, 1 bit: the serial bit under test.
REQ-007 SHALL have port data_valid, input, 1 bit: data_in is sampled only on cycles where this is high.
REQ-008 SHALL have port clr_err, input, 1 bit: synchronous clear of err_cnt.
REQ-009 SHALL have port match, output, 1 bit: a one-cycle pulse when the 6-bit window equals PATTERN.
REQ-010 SHALL have port locked, output, 1 bit: high while the FSM is in state LOCKED.
REQ-011 SHALL have port err, output, 1 bit: a one-cycle pulse on a bit mismatch while locked.
REQ-012 SHALL have port err_cnt, output, 8 bits: a saturating count of bit errors.
REQ-013 SHALL have port phase, output, 3 bits: the expected period index (0..5) of the next bit; it is 0 when not locked.

Function
REQ-014 SHALL register all outputs: each response appears on the cycle after the valid bit that caused it is sampled.
REQ-015 SHALL shift the window on every valid bit as window <= {data_in, window[5:1]} (newest bit in the MSB), and count fill up to a saturation of 6.
REQ-016 SHALL pulse match in any state when fill has reached 6 and the updated window equals PATTERN.
REQ-017 SHALL use FSM states HUNT, VERIFY and LOCKED; the reset state is HUNT.
REQ-018 HUNT: on a window match, go to VERIFY with the expected index set to 0 and the clean-period count set to 0.
REQ-019 VERIFY: compare each valid bit with PATTERN[index], then advance index modulo 6.
  - On a mismatch: go to HUNT without asserting err. The window is kept, so hunting resumes on the next bit.
  - On a wrap from index 5 to 0: increment the clean-period count.
  - When the count reaches LOCK_PERIODS: go to LOCKED.
REQ-020 LOCKED: compare each valid bit with PATTERN[phase], then advance phase modulo 6.
  - On a mismatch: pulse err, increment err_cnt (saturating at 255) and increment the error accumulator.
REQ-021 SHALL clear the error accumulator at each phase wrap from 5 to 0 when that whole period had no error.
REQ-022 SHALL go to HUNT and deassert locked on the same edge where the error accumulator reaches UNLOCK_ERRS; phase returns to 0.
REQ-023 With data_valid low, SHALL hold all state, window, counters and phase, and drive match and err low.
REQ-024 clr_err SHALL take priority over an error on the same cycle: err_cnt becomes 0, while the err pulse and the accumulator still update.
REQ-025 SHALL leave err_cnt unchanged when transitions between HUNT and VERIFY occur.

Reset
REQ-026 While rst is high, SHALL force state HUNT, window 0, fill 0, all counters 0, and match, locked, err, err_cnt and phase all 0.
REQ-027 rst SHALL override every other input on the same edge, including during LOCKED.

Structure
REQ-028 SHALL take the following from a shared package seq_pkg:
  - the state enum (HUNT, VERIFY, LOCKED);
  - PAT_LEN = 6;
  - the default pattern 6'b110100.
REQ-029 MAY use one sub-module, sequence_window (the shift window, fill counter and equality compare); the FSM and counters stay in the top module.

Verification
REQ-030 After reset, continuous valid stream 0,0,1,0,1,1 repeated:
  - match pulses after bits 6, 12 and 18;
  - locked rises the cycle after bit 18;
  - err_cnt stays 0.
REQ-031 Junk bits 1,1 followed by the pattern stream: the first match comes after bit 8 and locked rises after bit 20.
REQ-032 While locked, invert one bit at phase 2:
  - err pulses once and err_cnt becomes 1;
  - locked stays high;
  - the next clean period clears the accumulator, so a later single error also keeps lock.
REQ-033 While locked, inject 3 errors within one period:
  - locked falls the cycle after the third error and phase becomes 0;
  - err_cnt is 3;
  - re-lock occurs after 3 further clean periods of the pattern.
REQ-034 data_valid is low for 10 cycles in mid-period while locked: no output change. After the gap, the stream resumes with the correct bits and with no error.
REQ-035 Mismatch during VERIFY leads to HUNT with err low and err_cnt 0. Asserting rst while locked with err_cnt 5 gives all outputs 0 on the next cycle.
